izh_spike_decoder: RTL and testbench

Spike decoder for the 8-bit signed membrane-voltage stream produced by the Izhikevich neuron core (v[17:10], i.e. the value driven on uo_out). It detects spikes with threshold/re-arm hysteresis and measures the inter-spike interval (ISI) in samples. Each spike is tagged as first, burst or saturated, and the events are queued in a small FIFO behind a valid/ready handshake. It sits downstream of the neuron as its reader, feeding a host readout or spike-train logic.

---
 rtl/izh_pkg.sv | 31 +++
 rtl/izh_evt_fifo.sv | 75 +++++++
 rtl/izh_spike_decoder.sv | 159 +++++++++++++++
 tb/tb_izh_spike_decoder.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/izh_pkg.sv
// -----------------------------------------------------------------------------
// izh_pkg
// Shared definitions for the Izhikevich spike-decoder slice.
//   IZH_ISI_W       default ISI field width
//   IZH_SPIKE_TH_Q  default spike threshold (30 mV in the neuron's v[17:10] scale)
//   IZH_REARM_TH_Q  default re-arm threshold
//   izh_state_t     detector FSM state
//   izh_evt_t       spike event record at the default ISI width
// -----------------------------------------------------------------------------
package izh_pkg;

    localparam int IZH_ISI_W = 16;

    localparam logic signed [7:0] IZH_SPIKE_TH_Q = 8'sd16;
    localparam logic signed [7:0] IZH_REARM_TH_Q = -8'sd16;

    typedef enum logic {
        ST_ARMED = 1'b0,
        ST_FIRED = 1'b1
    } izh_state_t;

    // Field order is shared with the width-parameterised record in the top
    // level, so both pack identically.
    typedef struct packed {
        logic [IZH_ISI_W-1:0] isi;
        logic                 first;
        logic                 burst;
        logic                 sat;
    } izh_evt_t;

endpackage

// File: rtl/izh_evt_fifo.sv
// -----------------------------------------------------------------------------
// izh_evt_fifo
// Synchronous event FIFO with registered occupancy. The head entry is read
// straight from storage, so the consumer sees it the cycle after the push.
//   clk, rst_n  clock, asynchronous active-low reset
//   clr         synchronous clear (empties the FIFO)
//   push        write push_data (ignored while full unless popping)
//   push_data   event to store
//   pop         consumer accepts head (ignored while empty)
//   head        oldest stored event
//   empty/full  occupancy flags
//   overflow    push attempted while full with no pop in the same cycle
// -----------------------------------------------------------------------------
module izh_evt_fifo
    import izh_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type evt_t = izh_evt_t
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic push,
    input  evt_t push_data,
    input  logic pop,
    output evt_t head,
    output logic empty,
    output logic full,
    output logic overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    evt_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty    = (count == '0);
    assign full     = (count == FULL_CNT);
    assign do_pop   = pop & ~empty;
    // A pop frees the slot being written, so a full FIFO can still accept.
    assign do_push  = push & (~full | do_pop);
    assign overflow = push & ~do_push;
    assign head     = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage is data only; occupancy decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/izh_spike_decoder.sv
// -----------------------------------------------------------------------------
// izh_spike_decoder
// Detects spikes in the neuron's 8-bit signed membrane-voltage stream using
// threshold / re-arm hysteresis, measures the inter-spike interval in valid
// samples, tags each spike (first / burst / saturated) and queues the events
// behind a valid/ready handshake.
//   clk, rst_n   clock, asynchronous active-low reset
//   clr          synchronous clear, same effect as reset, highest priority
//   v_valid      v_in carries a new sample this cycle
//   v_in         signed membrane voltage sample
//   spike_pulse  one-cycle pulse, the cycle after the spike sample
//   evt_valid    FIFO head valid
//   evt_ready    consumer accepts the head
//   evt_isi      head ISI in samples (saturating)
//   evt_first    head is the first spike since reset/clr
//   evt_burst    head ISI <= BURST_ISI and not first
//   evt_sat      head ISI counter saturated
//   drop_cnt     events lost to a full FIFO, saturating at 255
//   spike_cnt    total spikes detected, wraps
// -----------------------------------------------------------------------------
module izh_spike_decoder
    import izh_pkg::*;
#(
    parameter int                ISI_W      = IZH_ISI_W,
    parameter int                FIFO_DEPTH = 4,
    parameter logic signed [7:0] SPIKE_TH   = IZH_SPIKE_TH_Q,
    parameter logic signed [7:0] REARM_TH   = IZH_REARM_TH_Q,
    parameter int                BURST_ISI  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr,
    input  logic               v_valid,
    input  logic signed [7:0]  v_in,
    output logic               spike_pulse,
    output logic               evt_valid,
    input  logic               evt_ready,
    output logic [ISI_W-1:0]   evt_isi,
    output logic               evt_first,
    output logic               evt_burst,
    output logic               evt_sat,
    output logic [7:0]         drop_cnt,
    output logic [15:0]        spike_cnt
);

    // Event record at this instance's ISI width (same layout as izh_evt_t).
    typedef struct packed {
        logic [ISI_W-1:0] isi;
        logic             first;
        logic             burst;
        logic             sat;
    } evt_t;

    localparam logic [ISI_W-1:0] ISI_MAX    = '1;
    // isi_cnt at or above this means the reported ISI reaches ISI_MAX.
    localparam logic [ISI_W-1:0] ISI_SAT_TH = ISI_MAX - 1'b1;
    localparam logic [ISI_W-1:0] BURST_LIM  =
        (longint'(BURST_ISI) >= (64'd1 << ISI_W)) ? ISI_MAX : ISI_W'(BURST_ISI);

    function automatic logic [ISI_W-1:0] isi_sat_inc(input logic [ISI_W-1:0] x);
        return (x == ISI_MAX) ? x : x + 1'b1;
    endfunction

    function automatic logic [7:0] drop_sat_inc(input logic [7:0] x);
        return (x == 8'hFF) ? x : x + 1'b1;
    endfunction

    izh_state_t       state_q;
    izh_state_t       state_d;
    logic [ISI_W-1:0] isi_cnt;
    logic             first_flag;
    logic             fire_p0;
    evt_t             evt_p0;
    evt_t             head;
    logic             fifo_empty;
    logic             fifo_full;
    logic             fifo_ovf;

    // ---- stage 0: sample decode (combinational from v_in) ----
    always_comb begin
        state_d = state_q;
        fire_p0 = 1'b0;
        if (v_valid) begin
            case (state_q)
                ST_ARMED: begin
                    if (v_in > SPIKE_TH) begin
                        fire_p0 = 1'b1;
                        state_d = ST_FIRED;
                    end
                end
                ST_FIRED: begin
                    if (v_in < REARM_TH) state_d = ST_ARMED;
                end
                default: state_d = ST_ARMED;
            endcase
        end
    end

    always_comb begin
        evt_p0       = '0;
        evt_p0.isi   = isi_sat_inc(isi_cnt);
        evt_p0.first = first_flag;
        evt_p0.burst = ~first_flag & (isi_sat_inc(isi_cnt) <= BURST_LIM);
        evt_p0.sat   = (isi_cnt >= ISI_SAT_TH);
    end

    // ---- stage 1: detector state, counters and event queue ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_ARMED;
            isi_cnt     <= '0;
            first_flag  <= 1'b1;
            spike_pulse <= 1'b0;
            spike_cnt   <= '0;
            drop_cnt    <= '0;
        end else if (clr) begin
            state_q     <= ST_ARMED;
            isi_cnt     <= '0;
            first_flag  <= 1'b1;
            spike_pulse <= 1'b0;
            spike_cnt   <= '0;
            drop_cnt    <= '0;
        end else begin
            state_q     <= state_d;
            spike_pulse <= fire_p0;
            // The spike sample closes the interval, so the count restarts at 0.
            if (v_valid) isi_cnt <= fire_p0 ? '0 : isi_sat_inc(isi_cnt);
            if (fire_p0) begin
                first_flag <= 1'b0;
                spike_cnt  <= spike_cnt + 1'b1;
            end
            if (fifo_ovf) drop_cnt <= drop_sat_inc(drop_cnt);
        end
    end

    izh_evt_fifo #(
        .DEPTH (FIFO_DEPTH),
        .evt_t (evt_t)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .push      (fire_p0),
        .push_data (evt_p0),
        .pop       (evt_ready),
        .head      (head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .overflow  (fifo_ovf)
    );

    // Fields read as zero while nothing is queued, so reset leaves no stale event.
    assign evt_valid = ~fifo_empty;
    assign evt_isi   = fifo_empty ? '0 : head.isi;
    assign evt_first = ~fifo_empty & head.first;
    assign evt_burst = ~fifo_empty & head.burst;
    assign evt_sat   = ~fifo_empty & head.sat;

endmodule

// File: tb/tb_izh_spike_decoder.sv
module tb_izh_spike_decoder;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              clr;
    logic              v_valid;
    logic signed [7:0] v_in;
    logic              evt_ready;

    logic        spike_pulse, evt_valid, evt_first, evt_burst, evt_sat;
    logic [15:0] evt_isi, spike_cnt;
    logic [7:0]  drop_cnt;

    logic        s_spike_pulse, s_evt_valid, s_evt_first, s_evt_burst, s_evt_sat;
    logic [3:0]  s_evt_isi;
    logic [15:0] s_spike_cnt;
    logic [7:0]  s_drop_cnt;

    always #5 clk = ~clk;

    izh_spike_decoder dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .v_valid(v_valid), .v_in(v_in),
        .spike_pulse(spike_pulse), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_isi(evt_isi), .evt_first(evt_first), .evt_burst(evt_burst),
        .evt_sat(evt_sat), .drop_cnt(drop_cnt), .spike_cnt(spike_cnt)
    );

    izh_spike_decoder #(.ISI_W(4)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .v_valid(v_valid), .v_in(v_in),
        .spike_pulse(s_spike_pulse), .evt_valid(s_evt_valid), .evt_ready(evt_ready),
        .evt_isi(s_evt_isi), .evt_first(s_evt_first), .evt_burst(s_evt_burst),
        .evt_sat(s_evt_sat), .drop_cnt(s_drop_cnt), .spike_cnt(s_spike_cnt)
    );

    typedef struct {
        int isi;
        bit first;
        bit burst;
        bit sat;
        int cyc;
    } rec_t;

    rec_t q[$];
    rec_t qs[$];
    int   cyc    = 0;
    int   pulses = 0;
    int   n_chk  = 0;
    int   n_pass = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every accepted event; inputs are stable at the falling edge.
    always @(negedge clk) begin
        if (evt_valid && evt_ready)
            q.push_back('{isi: int'(evt_isi), first: evt_first, burst: evt_burst,
                          sat: evt_sat, cyc: cyc});
        if (s_evt_valid && evt_ready)
            qs.push_back('{isi: int'(s_evt_isi), first: s_evt_first, burst: s_evt_burst,
                           sat: s_evt_sat, cyc: cyc});
        if (spike_pulse) pulses++;
    end

    task automatic check(input string tag, input longint act, input longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    endtask

    task automatic chk_evt(input string tag, input bit use_s, input int idx,
                           input int isi, input bit first, input bit burst, input bit sat);
        rec_t r;
        int   n;
        n = use_s ? qs.size() : q.size();
        if (idx < n) begin
            if (use_s) r = qs[idx];
            else       r = q[idx];
            check({tag, "_isi"},   r.isi,   isi);
            check({tag, "_first"}, r.first, first);
            check({tag, "_burst"}, r.burst, burst);
            check({tag, "_sat"},   r.sat,   sat);
        end else begin
            check({tag, "_present"}, n, idx + 1);
        end
    endtask

    task automatic send(input int v);
        v_valid = 1'b1;
        v_in    = 8'(v);
        @(posedge clk); #1;
        v_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic quiet(input int n);
        repeat (n) send(-20);
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        q.delete();
        qs.delete();
        pulses = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; clr = 1'b0; v_valid = 1'b0; v_in = '0; evt_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        check("rst_evt_valid",   evt_valid,   0);
        check("rst_spike_pulse", spike_pulse, 0);
        check("rst_drop_cnt",    drop_cnt,    0);
        check("rst_spike_cnt",   spike_cnt,   0);

        // Basic ISI measurement
        repeat (5) send(-45);
        send(20);
        check("t1_pulse",     spike_pulse, 1);
        check("t1_evt_valid", evt_valid,   1);
        send(-40);
        check("t1_pulse_one", spike_pulse, 0);
        repeat (13) send(-40);
        send(20);
        idle(3);
        check("t1_nevt", q.size(), 2);
        chk_evt("t1_e0", 0, 0, 6, 1, 0, 0);
        chk_evt("t1_e1", 0, 1, 15, 0, 0, 0);
        check("t1_spike_cnt", spike_cnt, 2);
        check("t1_pulses",    pulses,    2);

        // Hysteresis: 0 does not re-arm, -20 does
        do_clr();
        check("clr_evt_valid", evt_valid, 0);
        send(20); send(20); send(0); send(20); send(-20); send(20);
        idle(3);
        check("hy_nevt",   q.size(), 2);
        check("hy_pulses", pulses,   2);
        chk_evt("hy_e0", 0, 0, 1, 1, 0, 0);
        chk_evt("hy_e1", 0, 1, 5, 0, 1, 0);

        // Burst tag boundaries
        do_clr();
        send(20); quiet(5); send(20); quiet(7); send(20); quiet(8); send(20);
        idle(3);
        chk_evt("bu_e0", 0, 0, 1, 1, 0, 0);
        chk_evt("bu_e1", 0, 1, 6, 0, 1, 0);
        chk_evt("bu_e2", 0, 2, 8, 0, 1, 0);
        chk_evt("bu_e3", 0, 3, 9, 0, 0, 0);

        // Backpressure: 6 spikes into 4 entries
        do_clr();
        evt_ready = 1'b0;
        send(20);
        for (int k = 1; k <= 5; k++) begin
            quiet(k);
            send(20);
        end
        idle(2);
        check("bp_drop_cnt",  drop_cnt,  2);
        check("bp_spike_cnt", spike_cnt, 6);
        check("bp_evt_valid", evt_valid, 1);
        check("bp_head_isi",  evt_isi,   1);
        idle(3);
        check("bp_head_stable", evt_isi,  1);
        check("bp_no_pop",      q.size(), 0);
        evt_ready = 1'b1;
        idle(6);
        check("bp_nevt", q.size(), 4);
        chk_evt("bp_e0", 0, 0, 1, 1, 0, 0);
        for (int k = 1; k < 4; k++) begin
            chk_evt($sformatf("bp_e%0d", k), 0, k, k + 1, 0, 1, 0);
            if (k < q.size())
                check($sformatf("bp_gap%0d", k), q[k].cyc - q[k-1].cyc, 1);
        end
        check("bp_drained", evt_valid, 0);

        // Saturation on the 4-bit ISI instance; v_valid gaps do not count
        do_clr();
        send(20); quiet(20); send(20);
        for (int k = 0; k < 13; k++) begin
            send(-20);
            idle(1);
        end
        send(20);
        idle(3);
        chk_evt("sa_e0", 1, 0, 1, 1, 0, 0);
        chk_evt("sa_e1", 1, 1, 15, 0, 0, 1);
        chk_evt("sa_e2", 1, 2, 14, 0, 0, 0);
        chk_evt("sa_wide_e1", 0, 1, 21, 0, 0, 0);

        // Asynchronous reset during a drain
        do_clr();
        evt_ready = 1'b0;
        send(20); quiet(1); send(20); quiet(1); send(20);
        evt_ready = 1'b1;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("ar_evt_valid", evt_valid,   0);
        check("ar_spike_cnt", spike_cnt,   0);
        check("ar_drop_cnt",  drop_cnt,    0);
        check("ar_pulse",     spike_pulse, 0);
        @(negedge clk);
        rst_n = 1'b1;
        q.delete(); qs.delete(); pulses = 0;
        @(posedge clk); #1;
        send(20);
        idle(2);
        check("ar_nevt", q.size(), 1);
        chk_evt("ar_e0", 0, 0, 1, 1, 0, 0);
        check("ar_spike_cnt1", spike_cnt, 1);

        // Synchronous clear with a pending event; clr beats a spike sample
        evt_ready = 1'b0;
        quiet(1); send(20);
        check("cl_pending", evt_valid, 1);
        do_clr();
        check("cl_evt_valid", evt_valid, 0);
        check("cl_spike_cnt", spike_cnt, 0);
        clr = 1'b1; v_valid = 1'b1; v_in = 8'sd20;
        @(posedge clk); #1;
        clr = 1'b0; v_valid = 1'b0;
        check("cl_prio_pulse", spike_pulse, 0);
        check("cl_prio_cnt",   spike_cnt,   0);
        evt_ready = 1'b1;
        quiet(3); send(20);
        idle(2);
        check("cl_nevt", q.size(), 1);
        chk_evt("cl_e0", 0, 0, 4, 1, 0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
